// File: rtl/cdr_pkg.sv
// Shared types and default constants for the CDR period-adaptation slice.
package cdr_pkg;

  typedef enum logic [0:0] {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } cdr_lock_e;

  localparam int unsigned CDR_P_NOM   = 25;
  localparam int unsigned CDR_P_STEP  = 2;
  localparam int unsigned CDR_P_RANGE = 2;

endpackage

// File: rtl/cdr_vote_acc.sv
// Saturating signed early/late vote accumulator with synchronous clear.
// acc_eff_c already includes this cycle's vote so a decision can use it.
module cdr_vote_acc #(
  parameter int unsigned VOTE_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_vote,
  input  logic                     i_early,
  output logic signed [VOTE_W-1:0] o_acc_eff_c
);

  localparam logic signed [VOTE_W-1:0] ACC_MAX = VOTE_W'((1 << (VOTE_W - 1)) - 1);
  localparam logic signed [VOTE_W-1:0] ACC_MIN = -ACC_MAX;

  logic signed [VOTE_W-1:0] acc;

  // Symmetric saturation: never step past +/-ACC_MAX.
  always_comb begin
    o_acc_eff_c = acc;
    if (i_vote) begin
      if (i_early) begin
        if (acc != ACC_MAX) o_acc_eff_c = acc + VOTE_W'(1);
      end else begin
        if (acc != ACC_MIN) o_acc_eff_c = acc - VOTE_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) acc <= '0;
    else                 acc <= o_acc_eff_c;
  end

endmodule

// File: rtl/cdr_period_adapt.sv
// CDR sample-period adjuster: windowed vote decisions move the period count
// within [P_MIN, P_MAX]; an ACQ/LOCKED machine with hysteresis tracks stability.
module cdr_period_adapt
  import cdr_pkg::*;
#(
  parameter int unsigned W_P      = 6,
  parameter int unsigned P_NOM    = CDR_P_NOM,
  parameter int unsigned P_STEP   = CDR_P_STEP,
  parameter int unsigned P_RANGE  = CDR_P_RANGE,
  parameter int unsigned VOTE_W   = 4,
  parameter int unsigned VOTE_TH  = 3,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned UNLOCK_N = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_resync,
  input  logic           i_T,
  input  logic           i_E,
  input  logic           i_upd,
  output logic [W_P-1:0] o_nb_P,
  output logic           o_adj_up,
  output logic           o_adj_dn,
  output logic           o_at_limit,
  output logic           o_locked
);

  localparam int unsigned P_MIN = P_NOM - P_RANGE;
  localparam int unsigned P_MAX = P_NOM + P_RANGE;
  localparam int unsigned XW    = W_P + 2;
  localparam int unsigned QC_W  = $clog2(LOCK_N + 1);
  localparam int unsigned MC_W  = $clog2(UNLOCK_N + 1);

  localparam logic [XW-1:0] STEP_X = XW'(P_STEP);
  localparam logic [XW-1:0] MIN_X  = XW'(P_MIN);
  localparam logic [XW-1:0] MAX_X  = XW'(P_MAX);
  localparam logic signed [VOTE_W-1:0] TH_P = VOTE_W'(VOTE_TH);
  localparam logic signed [VOTE_W-1:0] TH_N = -TH_P;

  if (P_STEP == 0 || (P_RANGE % P_STEP) != 0) begin : g_chk_step
    $error("P_RANGE must be a non-zero multiple of P_STEP");
  end
  if (P_NOM <= P_RANGE || P_MAX >= (1 << W_P)) begin : g_chk_range
    $error("period bounds must satisfy 0 < P_MIN and P_MAX < 2**W_P");
  end
  if (VOTE_TH < 1 || VOTE_TH > (1 << (VOTE_W - 1)) - 1) begin : g_chk_th
    $error("VOTE_TH out of accumulator range");
  end
  if (LOCK_N < 1 || UNLOCK_N < 1) begin : g_chk_cnt
    $error("LOCK_N and UNLOCK_N must be at least 1");
  end

  logic signed [VOTE_W-1:0] acc_eff;
  logic                     want_up, want_dn, adjusted, up_ok, dn_ok;
  logic [XW-1:0]            nb_x;

  cdr_lock_e        state, state_n;
  logic [QC_W-1:0]  quiet_cnt, quiet_n;
  logic [MC_W-1:0]  miss_cnt, miss_n;
  logic [W_P-1:0]   nb_n;
  logic             up_n, dn_n, lim_n, locked_n;

  // Window accumulator clears on every decision and on resync.
  cdr_vote_acc #(.VOTE_W(VOTE_W)) u_acc (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (i_upd || i_resync),
    .i_vote      (i_T),
    .i_early     (i_E),
    .o_acc_eff_c (acc_eff)
  );

  assign want_up  = (acc_eff >= TH_P);
  assign want_dn  = (acc_eff <= TH_N);
  assign adjusted = want_up || want_dn;
  assign nb_x     = XW'(o_nb_P);
  assign up_ok    = (nb_x + STEP_X) <= MAX_X;
  assign dn_ok    = nb_x >= (MIN_X + STEP_X);

  // Next-state and registered-output logic; only a decision strobe changes anything.
  always_comb begin
    state_n  = state;
    quiet_n  = quiet_cnt;
    miss_n   = miss_cnt;
    nb_n     = o_nb_P;
    up_n     = 1'b0;
    dn_n     = 1'b0;
    lim_n    = o_at_limit;
    locked_n = o_locked;
    if (i_upd) begin
      lim_n = (want_up && !up_ok) || (want_dn && !dn_ok);
      if (want_up && up_ok) begin
        nb_n = o_nb_P + W_P'(P_STEP);
        up_n = 1'b1;
      end else if (want_dn && dn_ok) begin
        nb_n = o_nb_P - W_P'(P_STEP);
        dn_n = 1'b1;
      end
      case (state)
        ACQ: begin
          if (adjusted) begin
            quiet_n = '0;
          end else begin
            if (quiet_cnt != QC_W'(LOCK_N)) quiet_n = quiet_cnt + QC_W'(1);
            if (quiet_n == QC_W'(LOCK_N)) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
              miss_n   = '0;
            end
          end
        end
        LOCKED: begin
          if (!adjusted) begin
            miss_n = '0;
          end else begin
            if (miss_cnt != MC_W'(UNLOCK_N)) miss_n = miss_cnt + MC_W'(1);
            if (miss_n == MC_W'(UNLOCK_N)) begin
              state_n  = ACQ;
              locked_n = 1'b0;
              quiet_n  = '0;
            end
          end
        end
        default: state_n = ACQ;
      endcase
    end
  end

  // Resync restores the reset image on every register.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_resync) begin
      state      <= ACQ;
      quiet_cnt  <= '0;
      miss_cnt   <= '0;
      o_nb_P     <= W_P'(P_NOM);
      o_adj_up   <= 1'b0;
      o_adj_dn   <= 1'b0;
      o_at_limit <= 1'b0;
      o_locked   <= 1'b0;
    end else begin
      state      <= state_n;
      quiet_cnt  <= quiet_n;
      miss_cnt   <= miss_n;
      o_nb_P     <= nb_n;
      o_adj_up   <= up_n;
      o_adj_dn   <= dn_n;
      o_at_limit <= lim_n;
      o_locked   <= locked_n;
    end
  end

endmodule

// File: tb/tb_cdr_period_adapt.sv
// Scoreboard bench for cdr_period_adapt: stimulus queues hand-computed results,
// a monitor checks them the cycle after each decision/reset/resync.
module tb_cdr_period_adapt;

  logic       i_clk = 1'b0;
  logic       i_rst, i_resync, i_T, i_E, i_upd;
  logic [5:0] o_nb_P;
  logic       o_adj_up, o_adj_dn, o_at_limit, o_locked;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [5:0] nb;
    logic       up;
    logic       dn;
    logic       lim;
    logic       lck;
  } exp_t;

  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  cdr_period_adapt dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_resync   (i_resync),
    .i_T        (i_T),
    .i_E        (i_E),
    .i_upd      (i_upd),
    .o_nb_P     (o_nb_P),
    .o_adj_up   (o_adj_up),
    .o_adj_dn   (o_adj_dn),
    .o_at_limit (o_at_limit),
    .o_locked   (o_locked)
  );

  task automatic push(input string n, input int nb, input bit up, input bit dn,
                      input bit lim, input bit lck);
    exp_t e;
    e.name = n; e.nb = 6'(nb); e.up = up; e.dn = dn; e.lim = lim; e.lck = lck;
    sb.push_back(e);
  endtask

  task automatic step(input bit t, input bit e, input bit upd, input bit rs);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1; i_T = t; i_E = e; i_upd = upd; i_resync = rs;
  endtask

  // ne early votes, nl late votes, then a decision cycle with an optional vote.
  task automatic window(input string n, input int ne, input int nl, input bit st,
                        input bit se, input int nb, input bit up, input bit dn,
                        input bit lim, input bit lck);
    for (int k = 0; k < ne; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < nl; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(st, se, 1'b1, 1'b0);
    push(n, nb, up, dn, lim, lck);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: an expected record is due the cycle after every decision, reset or resync.
  initial begin
    bit   dec;
    exp_t e;
    forever begin
      @(posedge i_clk);
      dec = (i_upd === 1'b1) || (i_resync === 1'b1) || (i_rst !== 1'b1);
      @(negedge i_clk);
      total++;
      if (dec) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL no_expectation: got nb=%0d but scoreboard empty", o_nb_P);
        end else begin
          e = sb.pop_front();
          if ({o_nb_P, o_adj_up, o_adj_dn, o_at_limit, o_locked} !==
              {e.nb, e.up, e.dn, e.lim, e.lck}) begin
            bad++;
            $display("FAIL %s: got nb=%0d up=%0b dn=%0b lim=%0b lck=%0b want nb=%0d up=%0b dn=%0b lim=%0b lck=%0b",
                     e.name, o_nb_P, o_adj_up, o_adj_dn, o_at_limit, o_locked,
                     e.nb, e.up, e.dn, e.lim, e.lck);
          end
        end
      end else if (o_adj_up !== 1'b0 || o_adj_dn !== 1'b0) begin
        bad++;
        $display("FAIL stray_pulse: got up=%0b dn=%0b want 0 0", o_adj_up, o_adj_dn);
      end
    end
  end

  initial begin
    i_rst = 1'b0; i_resync = 1'b0; i_T = 1'b0; i_E = 1'b0; i_upd = 1'b0;
    push("reset0", 25, 0, 0, 0, 0);
    push("reset1", 25, 0, 0, 0, 0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Step up, then blocked at P_MAX.
    window("up_27",      3, 0, 0, 0, 27, 1, 0, 0, 0);
    window("up_blocked", 3, 0, 0, 0, 27, 0, 0, 1, 0);

    // Resync to nominal, then sub-threshold windows; acc must restart at 0.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    push("resync_a", 25, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    window("mixed_quiet", 2, 1, 0, 0, 25, 0, 0, 0, 0);
    window("acc_cleared", 2, 0, 0, 0, 25, 0, 0, 0, 0);

    // Simultaneous vote counts; walk down to P_MIN and get blocked.
    window("simul_up",   2, 0, 1, 1, 27, 1, 0, 0, 0);
    window("dn_25",      0, 3, 0, 0, 25, 0, 1, 0, 0);
    window("dn_23",      0, 3, 0, 0, 23, 0, 1, 0, 0);
    window("dn_blocked", 0, 3, 0, 0, 23, 0, 0, 1, 0);

    // Lock after LOCK_N quiet windows, unlock after UNLOCK_N adjusted ones.
    window("quiet1", 0, 0, 0, 0, 23, 0, 0, 0, 0);
    window("quiet2", 0, 0, 0, 0, 23, 0, 0, 0, 0);
    window("quiet3", 0, 0, 0, 0, 23, 0, 0, 0, 0);
    window("lock",   0, 0, 0, 0, 23, 0, 0, 0, 1);
    window("miss1",  3, 0, 0, 0, 25, 1, 0, 0, 1);
    window("unlock", 3, 0, 0, 0, 27, 1, 0, 0, 0);

    // Relock, then adjust/quiet/adjust must not unlock.
    window("rq1",   0, 0, 0, 0, 27, 0, 0, 0, 0);
    window("rq2",   0, 0, 0, 0, 27, 0, 0, 0, 0);
    window("rq3",   0, 0, 0, 0, 27, 0, 0, 0, 0);
    window("relock", 0, 0, 0, 0, 27, 0, 0, 0, 1);
    window("hyst_adj1", 0, 3, 0, 0, 25, 0, 1, 0, 1);
    window("hyst_quiet", 0, 0, 0, 0, 25, 0, 0, 0, 1);
    window("hyst_adj2", 0, 3, 0, 0, 23, 0, 1, 0, 1);

    // Resync wins over a simultaneous decision with pending votes.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    push("resync_b", 25, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    window("post_rs_acc0", 2, 0, 0, 0, 25, 0, 0, 0, 0);
    window("post_rs_q2",   0, 0, 0, 0, 25, 0, 0, 0, 0);
    window("post_rs_q3",   0, 0, 0, 0, 25, 0, 0, 0, 0);
    window("post_rs_lock", 0, 0, 0, 0, 25, 0, 0, 0, 1);

    // Accumulator saturates at +7: 10 early then 10 late nets -3.
    window("acc_sat", 10, 10, 0, 0, 23, 0, 1, 0, 1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge i_clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations want 0", sb.size());
    end
    repeat (2) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
